// File: rtl/mem_arb_pkg.sv
// Shared definitions for the CPU/host memory arbiter: FSM states, requester IDs
// and default bus widths.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam logic CPU  = 1'b0;
  localparam logic HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU and host loader ports.
// The CPU wins by default; a host that has waited MAX_WAIT CPU wins is forced through.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 3,
  parameter int WAIT_W   = 2
) (
  input  logic              cpu_pending,
  input  logic              host_pending,
  input  logic              host_mode,
  input  logic [WAIT_W-1:0] wait_cnt,
  output logic              grant_valid,
  output logic              grant_port
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic cpu_elig;

  assign cpu_elig    = cpu_pending & ~host_mode;
  assign grant_valid = cpu_elig | host_pending;
  assign grant_port  = (host_pending && (!cpu_elig || wait_cnt == WAIT_MAX)) ? HOST : CPU;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: IDLE arbitrates,
// ACCESS presents the latched request to the RAM, RESP returns data and pulses ack.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_mode,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              grant_host
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  arb_state_t        state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              we_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;

  logic cpu_pending;
  logic host_pending;
  logic grant_valid;
  logic grant_port;

  // A requester is never re-sampled in its own ack cycle.
  assign cpu_pending  = cpu_req & ~cpu_ack;
  assign host_pending = host_req & ~host_ack;

  mem_arb_pick #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_pick (
    .cpu_pending  (cpu_pending),
    .host_pending (host_pending),
    .host_mode    (host_mode),
    .wait_cnt     (wait_cnt_reg),
    .grant_valid  (grant_valid),
    .grant_port   (grant_port)
  );

  assign ram_en    = (state_reg == ACCESS);
  assign ram_we    = ram_en & we_reg;
  assign ram_addr  = addr_reg;
  assign ram_wdata = wdata_reg;
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      we_reg       <= 1'b0;
      wait_cnt_reg <= '0;
      grant_host   <= 1'b0;
      cpu_ack      <= 1'b0;
      host_ack     <= 1'b0;
      cpu_rdata    <= '0;
      host_rdata   <= '0;
    end else begin
      cpu_ack  <= 1'b0;
      host_ack <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            addr_reg   <= (grant_port == HOST) ? host_addr  : cpu_addr;
            wdata_reg  <= (grant_port == HOST) ? host_wdata : cpu_wdata;
            we_reg     <= (grant_port == HOST) ? host_we    : cpu_we;
            grant_host <= grant_port;
            state_reg  <= ACCESS;
            // Count CPU wins that leave an eligible host waiting.
            if (grant_port == HOST) begin
              wait_cnt_reg <= '0;
            end else if (host_pending && wait_cnt_reg != WAIT_MAX) begin
              wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
            end
          end
        end
        ACCESS: begin
          state_reg <= RESP;
        end
        RESP: begin
          if (grant_host) begin
            host_ack <= 1'b1;
            if (!we_reg) host_rdata <= ram_rdata;
          end else begin
            cpu_ack <= 1'b1;
            if (!we_reg) cpu_rdata <= ram_rdata;
          end
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM, a shadow memory model and
// an ack scoreboard checked on every falling edge.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, host_req, host_we, host_mode;
  logic [7:0]  cpu_addr, host_addr;
  logic [15:0] cpu_wdata, host_wdata;
  logic        cpu_ack, host_ack;
  logic [15:0] cpu_rdata, host_rdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic        busy, grant_host;

  typedef struct {
    logic        host;
    logic        we;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ram_mem [256];
  logic [15:0] exp_mem [256];
  int          vec  = 0;
  int          miss = 0;
  int          en_cnt = 0;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .host_mode  (host_mode),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .busy       (busy),
    .grant_host (grant_host)
  );

  // Behavioural single-port RAM with one-cycle read latency.
  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec++;
    assert (obs === expv) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Ack scoreboard plus per-cycle protocol checks.
  always @(negedge clock) begin
    if (reset_n) begin
      exp_t e;
      if (ram_en) en_cnt++;
      chk("ack_exclusive", {31'd0, cpu_ack & host_ack}, 32'd0);
      chk("ram_en_only_busy", {31'd0, ram_en & ~busy}, 32'd0);
      if (cpu_ack || host_ack) begin
        if (sb.size() == 0) begin
          chk("spurious_ack", {30'd0, cpu_ack, host_ack}, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("ack port=%s we=%0d rdata=%h", host_ack ? "HOST" : "CPU", e.we,
                   host_ack ? host_rdata : cpu_rdata);
          chk("ack_port", {31'd0, host_ack}, {31'd0, e.host});
          if (!e.we) chk("rdata", {16'd0, e.host ? host_rdata : cpu_rdata}, {16'd0, e.data});
        end
      end
    end
  end

  task automatic push(input logic host, input logic we, input logic [7:0] addr,
                      input logic [15:0] data);
    exp_t e;
    e.host = host;
    e.we   = we;
    e.data = we ? data : exp_mem[addr];
    if (we) exp_mem[addr] = data;
    sb.push_back(e);
  endtask

  task automatic single(input logic host, input logic we, input logic [7:0] addr,
                        input logic [15:0] data);
    int en0;
    bit got;
    push(host, we, addr, data);
    en0 = en_cnt;
    @(posedge clock); #1;
    if (host) begin
      host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = data;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (host ? host_ack : cpu_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_timeout", {31'd0, got}, 32'd1);
    cpu_req  = 1'b0;
    host_req = 1'b0;
    @(negedge clock);
    chk("ram_en_cycles", en_cnt - en0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  got;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 16'(i * 257) ^ 16'h5A5A;
      exp_mem[i] = 16'(i * 257) ^ 16'h5A5A;
    end
    ram_mem[8'h10] = 16'hBEEF;
    exp_mem[8'h10] = 16'hBEEF;
    ram_rdata = '0;
    reset_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_mode = 0;

    // Reset held for two cycles.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_host_ack", {31'd0, host_ack}, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant_host", {31'd0, grant_host}, 32'd0);
    chk("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    chk("rst_host_rdata", {16'd0, host_rdata}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // CPU read, host write, read-back from both ports.
    single(CPU, 1'b0, 8'h10, 16'h0000);
    single(HOST, 1'b1, 8'h20, 16'h1234);
    single(CPU, 1'b0, 8'h20, 16'h0000);
    single(HOST, 1'b0, 8'h20, 16'h0000);
    single(CPU, 1'b1, 8'h40, 16'hA55A);
    single(HOST, 1'b0, 8'h40, 16'h0000);

    // Starvation: host eligible at every CPU win; 4th arbitration forced to host.
    push(CPU, 1'b0, 8'h10, 16'h0);
    push(CPU, 1'b0, 8'h10, 16'h0);
    push(CPU, 1'b0, 8'h10, 16'h0);
    push(HOST, 1'b0, 8'h30, 16'h0);
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h30;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if (host_ack) begin
        n++;
        cpu_req = 1'b0;
        host_req = 1'b0;
        break;
      end else if (cpu_ack) begin
        n++;
        host_req = 1'b0;
      end else if (!host_req) begin
        host_req = 1'b1;
      end
    end
    chk("starve_acks", n, 32'd4);

    // host_mode blocks the CPU; CPU is served soon after it falls.
    push(HOST, 1'b0, 8'h30, 16'h0);
    push(HOST, 1'b0, 8'h30, 16'h0);
    @(posedge clock); #1;
    host_mode = 1'b1;
    cpu_req = 1'b1; cpu_addr = 8'h20; cpu_we = 1'b0;
    host_req = 1'b1; host_addr = 8'h30; host_we = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (host_ack) begin
        n++;
        if (n == 2) begin
          host_req = 1'b0;
          host_mode = 1'b0;
          break;
        end
      end
    end
    chk("hmode_host_acks", n, 32'd2);
    push(CPU, 1'b0, 8'h20, 16'h0);
    got = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      if (cpu_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("hmode_cpu_within_3", {31'd0, got}, 32'd1);
    cpu_req = 1'b0;

    // Reset during ACCESS aborts the read with no ack.
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_addr = 8'h10; cpu_we = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (ram_en) begin
        got = 1'b1;
        break;
      end
    end
    chk("abort_reached_access", {31'd0, got}, 32'd1);
    reset_n = 1'b0;
    cpu_req = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("abort_no_ack", {31'd0, cpu_ack}, 32'd0);
    end
    single(CPU, 1'b0, 8'h10, 16'h0000);

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
